// File: rtl/plab2_proc_mem_arbiter_pkg.sv
// Shared definitions for the processor/memory arbiter: port IDs, default
// message widths, the request-lock state encoding and a small port helper.
package plab2_proc_mem_arbiter_pkg;

  localparam logic PLAB2_PROC_MEM_ARB_IMEM = 1'b0;
  localparam logic PLAB2_PROC_MEM_ARB_DMEM = 1'b1;

  localparam int unsigned PLAB2_PROC_MEM_ARB_REQ_NBITS        = 78;
  localparam int unsigned PLAB2_PROC_MEM_ARB_RESP_NBITS       = 46;
  localparam int unsigned PLAB2_PROC_MEM_ARB_MAX_OUTSTANDING  = 4;

  // OPEN: grant is recomputed every cycle; LOCKED: a stalled request is held
  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // The port that is not p (two-port round robin)
  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/plab2_proc_mem_arb_tag_fifo.sv
// In-order tag FIFO recording which port issued each outstanding request.
// Ports: clk, rst_n (async active-low), push/push_tag (enqueue), pop (dequeue),
//        full, empty, head_tag (port ID of the oldest outstanding request).
// Push is ignored when full and pop when empty; push+pop together keep the
// count and advance both pointers.
module plab2_proc_mem_arb_tag_fifo
  import plab2_proc_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = PLAB2_PROC_MEM_ARB_MAX_OUTSTANDING
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head_tag
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] tags_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_tag = tags_q[head_q];

  // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        tags_q[tail_q] <= push_tag;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/plab2_proc_mem_arbiter.sv
// Merges the processor imem/dmem request ports onto one memory port with
// round-robin arbitration and routes in-order responses back by tag.
// Ports: clk, reset (async active-low); imemreq/dmemreq (in val/rdy),
//        imemresp/dmemresp (out val/rdy), memreq (out val/rdy),
//        memresp (in val/rdy), proto_err (sticky protocol error flag).
// Build option: define PLAB2_PROC_MEM_ARB_CHECK_EN to enable the protocol
// checker; otherwise proto_err is tied low.
module plab2_proc_mem_arbiter
  import plab2_proc_mem_arbiter_pkg::*;
#(
  parameter int unsigned REQ_NBITS       = PLAB2_PROC_MEM_ARB_REQ_NBITS,
  parameter int unsigned RESP_NBITS      = PLAB2_PROC_MEM_ARB_RESP_NBITS,
  parameter int unsigned MAX_OUTSTANDING = PLAB2_PROC_MEM_ARB_MAX_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [REQ_NBITS-1:0]  imemreq_msg,
  input  logic                  imemreq_val,
  output logic                  imemreq_rdy,

  output logic [RESP_NBITS-1:0] imemresp_msg,
  output logic                  imemresp_val,
  input  logic                  imemresp_rdy,

  input  logic [REQ_NBITS-1:0]  dmemreq_msg,
  input  logic                  dmemreq_val,
  output logic                  dmemreq_rdy,

  output logic [RESP_NBITS-1:0] dmemresp_msg,
  output logic                  dmemresp_val,
  input  logic                  dmemresp_rdy,

  output logic [REQ_NBITS-1:0]  memreq_msg,
  output logic                  memreq_val,
  input  logic                  memreq_rdy,

  input  logic [RESP_NBITS-1:0] memresp_msg,
  input  logic                  memresp_val,
  output logic                  memresp_rdy,

  output logic                  proto_err
);

  arb_state_e state_q, state_d;
  logic       lock_port_q, lock_port_d;
  logic       prio_q, prio_d;

  logic grant_vld;
  logic grant;
  logic grant_val;
  logic req_rdy;
  logic req_fire;
  logic resp_active;
  logic resp_fire;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;

  plab2_proc_mem_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (req_fire),
    .push_tag (grant),
    .pop      (resp_fire),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_tag (fifo_head)
  );

  // Arbitration state: lock and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_OPEN;
      lock_port_q <= PLAB2_PROC_MEM_ARB_DMEM;
      prio_q      <= PLAB2_PROC_MEM_ARB_DMEM;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      prio_q      <= prio_d;
    end
  end

  // Grant, request/response handshakes and next arbitration state.
  // Every val/rdy output is qualified by reset so it drops the moment reset asserts.
  always_comb begin
    state_d      = state_q;
    lock_port_d  = lock_port_q;
    prio_d       = prio_q;
    grant_vld    = 1'b0;
    grant        = prio_q;
    grant_val    = 1'b0;
    req_rdy      = 1'b0;
    req_fire     = 1'b0;
    resp_active  = 1'b0;
    resp_fire    = 1'b0;
    memreq_val   = 1'b0;
    memreq_msg   = imemreq_msg;
    imemreq_rdy  = 1'b0;
    dmemreq_rdy  = 1'b0;
    imemresp_val = 1'b0;
    dmemresp_val = 1'b0;
    memresp_rdy  = 1'b0;
    imemresp_msg = memresp_msg;
    dmemresp_msg = memresp_msg;

    if (state_q == ARB_LOCKED) begin
      grant_vld = 1'b1;
      grant     = lock_port_q;
    end else if (imemreq_val && dmemreq_val) begin
      grant_vld = 1'b1;
      grant     = prio_q;
    end else if (imemreq_val) begin
      grant_vld = 1'b1;
      grant     = PLAB2_PROC_MEM_ARB_IMEM;
    end else if (dmemreq_val) begin
      grant_vld = 1'b1;
      grant     = PLAB2_PROC_MEM_ARB_DMEM;
    end

    grant_val   = (grant == PLAB2_PROC_MEM_ARB_DMEM) ? dmemreq_val : imemreq_val;
    memreq_msg  = (grant == PLAB2_PROC_MEM_ARB_DMEM) ? dmemreq_msg : imemreq_msg;
    memreq_val  = reset && grant_vld && grant_val && !fifo_full;
    req_rdy     = reset && grant_vld && memreq_rdy && !fifo_full;
    imemreq_rdy = req_rdy && (grant == PLAB2_PROC_MEM_ARB_IMEM);
    dmemreq_rdy = req_rdy && (grant == PLAB2_PROC_MEM_ARB_DMEM);
    req_fire    = memreq_val && memreq_rdy;

    // A presented but unaccepted request pins the grant until it fires
    case (state_q)
      ARB_OPEN: begin
        if (memreq_val && !memreq_rdy) begin
          state_d     = ARB_LOCKED;
          lock_port_d = grant;
        end
      end
      ARB_LOCKED: begin
        if (!(memreq_val && !memreq_rdy)) begin
          state_d = ARB_OPEN;
        end
      end
      default: state_d = ARB_OPEN;
    endcase

    if (req_fire) begin
      prio_d = other_port(grant);
    end

    // Responses go to the port at the head of the tag FIFO
    resp_active  = reset && !fifo_empty;
    imemresp_val = resp_active && (fifo_head == PLAB2_PROC_MEM_ARB_IMEM) && memresp_val;
    dmemresp_val = resp_active && (fifo_head == PLAB2_PROC_MEM_ARB_DMEM) && memresp_val;
    memresp_rdy  = resp_active &&
                   ((fifo_head == PLAB2_PROC_MEM_ARB_DMEM) ? dmemresp_rdy : imemresp_rdy);
    resp_fire    = memresp_val && memresp_rdy;
  end

`ifdef PLAB2_PROC_MEM_ARB_CHECK_EN
  logic [REQ_NBITS-1:0] lock_msg_q;
  logic                 proto_err_q;
  logic                 err_empty_c;
  logic                 err_lock_c;

  assign err_empty_c = memresp_val && fifo_empty;
  assign err_lock_c  = (state_q == ARB_LOCKED) &&
                       (!grant_val || (memreq_msg != lock_msg_q));

  // Sticky protocol checker; remembers the stalled message to detect changes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_msg_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (memreq_val && !memreq_rdy) begin
        lock_msg_q <= memreq_msg;
      end
      if (err_empty_c) begin
        proto_err_q <= 1'b1;
        $display("[%0t] plab2_proc_mem_arbiter: memresp_val with no outstanding request", $time);
      end
      if (err_lock_c) begin
        proto_err_q <= 1'b1;
        $display("[%0t] plab2_proc_mem_arbiter: locked port dropped val or changed msg", $time);
      end
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_plab2_proc_mem_arbiter.sv
module tb_plab2_proc_mem_arbiter;

  localparam int unsigned REQ  = 78;
  localparam int unsigned RESP = 46;
  localparam int unsigned MAXO = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [REQ-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
  logic            imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
  logic            memreq_val, memreq_rdy;
  logic [RESP-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
  logic            imemresp_val, imemresp_rdy, dmemresp_val, dmemresp_rdy;
  logic            memresp_val, memresp_rdy;
  logic            proto_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  plab2_proc_mem_arbiter #(
    .REQ_NBITS (REQ), .RESP_NBITS (RESP), .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk (clk), .reset (reset),
    .imemreq_msg (imemreq_msg), .imemreq_val (imemreq_val), .imemreq_rdy (imemreq_rdy),
    .imemresp_msg (imemresp_msg), .imemresp_val (imemresp_val), .imemresp_rdy (imemresp_rdy),
    .dmemreq_msg (dmemreq_msg), .dmemreq_val (dmemreq_val), .dmemreq_rdy (dmemreq_rdy),
    .dmemresp_msg (dmemresp_msg), .dmemresp_val (dmemresp_val), .dmemresp_rdy (dmemresp_rdy),
    .memreq_msg (memreq_msg), .memreq_val (memreq_val), .memreq_rdy (memreq_rdy),
    .memresp_msg (memresp_msg), .memresp_val (memresp_val), .memresp_rdy (memresp_rdy),
    .proto_err (proto_err)
  );

  // {inputs iv,dv,mreq_rdy,mresp_val,iresp_rdy,dresp_rdy}, expected outputs, req source
  typedef struct {
    logic [5:0] in;
    logic [5:0] exp;
    int         src;   // 0 imem, 1 dmem, 2 don't care
  } vec_t;

  typedef struct {
    logic           port;
    logic [REQ-1:0] msg;
  } txn_t;

  vec_t tbl[17];
  txn_t mq[$];

  function automatic vec_t mk(input logic [5:0] in, input logic [5:0] exp, input int src);
    vec_t v;
    v.in = in; v.exp = exp; v.src = src;
    return v;
  endfunction

  // {memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val, memresp_rdy}
  function automatic logic [5:0] outs();
    return {memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val, memresp_rdy};
  endfunction

  function automatic logic [REQ-1:0] rnd_req();
    return REQ'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imemreq_val = 1'b0; dmemreq_val = 1'b0; memreq_rdy = 1'b0;
    memresp_val = 1'b0; imemresp_rdy = 1'b0; dmemresp_rdy = 1'b0;
    memresp_msg = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  logic           m_last, held_v, held_p, i_hold, d_hold;
  logic           cand_v, cand, full, e_mval, e_fire, e_iv, e_dv, e_mrr, e_rfire, has;
  logic [REQ-1:0] imsg, dmsg, xmsg;

  initial begin
    imsg = 78'h11_2233_4455_6677_8899;
    dmsg = 78'h2A_BBCC_DDEE_FF00_1122;

    // Reset state with every input asserted
    reset = 1'b0;
    imemreq_val = 1'b1; dmemreq_val = 1'b1; memreq_rdy = 1'b1;
    memresp_val = 1'b1; imemresp_rdy = 1'b1; dmemresp_rdy = 1'b1;
    imemreq_msg = imsg; dmemreq_msg = dmsg; memresp_msg = '0;
    #2;
    chk("reset_outs", 128'(outs()), 128'(6'b000000));
    chk("reset_proto_err", 128'(proto_err), 128'(1'b0));
    do_reset();

    // Table: contention, lock, full FIFO, push blocked during pop, response stall
    tbl[0]  = mk(6'b111000, 6'b101000, 1);
    tbl[1]  = mk(6'b111111, 6'b110011, 0);
    tbl[2]  = mk(6'b110000, 6'b100000, 1);
    tbl[3]  = mk(6'b110100, 6'b100100, 1);
    tbl[4]  = mk(6'b111110, 6'b101101, 1);
    tbl[5]  = mk(6'b101000, 6'b110000, 0);
    tbl[6]  = mk(6'b011000, 6'b101000, 1);
    tbl[7]  = mk(6'b101000, 6'b110000, 0);
    tbl[8]  = mk(6'b111000, 6'b000000, 2);
    tbl[9]  = mk(6'b111111, 6'b000011, 2);
    tbl[10] = mk(6'b111000, 6'b101000, 1);
    tbl[11] = mk(6'b001111, 6'b000101, 2);
    tbl[12] = mk(6'b001110, 6'b000010, 2);
    tbl[13] = mk(6'b001101, 6'b000011, 2);
    tbl[14] = mk(6'b001111, 6'b000101, 2);
    tbl[15] = mk(6'b001111, 6'b000011, 2);
    tbl[16] = mk(6'b001111, 6'b000000, 2);
    imemreq_msg = imsg; dmemreq_msg = dmsg;
    for (int i = 0; i < 17; i++) begin
      {imemreq_val, dmemreq_val, memreq_rdy, memresp_val, imemresp_rdy, dmemresp_rdy} = tbl[i].in;
      memresp_msg = RESP'(46'h1000 + 46'(i));
      #1;
      chk($sformatf("table_outs[%0d]", i), 128'(outs()), 128'(tbl[i].exp));
      if (tbl[i].src != 2)
        chk($sformatf("table_msg[%0d]", i), 128'(memreq_msg), 128'((tbl[i].src == 1) ? dmsg : imsg));
      if (tbl[i].exp[2])
        chk($sformatf("table_iresp[%0d]", i), 128'(imemresp_msg), 128'(memresp_msg));
      if (tbl[i].exp[1])
        chk($sformatf("table_dresp[%0d]", i), 128'(dmemresp_msg), 128'(memresp_msg));
      tick();
    end
    do_reset();

    // Basic routing: imem read of 0x100, memory answers 0xdeadbeef
    imemreq_msg = REQ'({3'd0, 8'h01, 32'h0000_0100, 2'd0, 32'h0});
    imemreq_val = 1'b1; memreq_rdy = 1'b1;
    #1;
    chk("basic_req", 128'(outs()), 128'(6'b110000));
    chk("basic_req_msg", 128'(memreq_msg), 128'(imemreq_msg));
    tick();
    imemreq_val = 1'b0; memresp_val = 1'b1; memresp_msg = RESP'(46'h0_01_DEAD_BEEF);
    imemresp_rdy = 1'b1; dmemresp_rdy = 1'b1;
    #1;
    chk("basic_resp", 128'(outs()), 128'(6'b000101));
    chk("basic_resp_data", 128'(imemresp_msg[31:0]), 128'(32'hDEAD_BEEF));
    tick();
    memresp_val = 1'b0;
    #1;
    chk("basic_empty", 128'(outs()), 128'(6'b000000));
    do_reset();

    // Backpressure lock: dmem stalls 3 cycles while imem (which holds priority) waits
    dmemreq_val = 1'b1; dmemreq_msg = dmsg; memreq_rdy = 1'b1;
    tick();
    xmsg = rnd_req();
    dmemreq_msg = xmsg; memreq_rdy = 1'b0;
    imemreq_msg = imsg;
    for (int c = 0; c < 3; c++) begin
      imemreq_val = (c != 0);
      #1;
      chk($sformatf("lock_outs[%0d]", c), 128'(outs()), 128'(6'b100000));
      chk($sformatf("lock_msg[%0d]", c), 128'(memreq_msg), 128'(xmsg));
      tick();
    end
    memreq_rdy = 1'b1;
    #1;
    chk("lock_fire", 128'(outs()), 128'(6'b101000));
    chk("lock_fire_msg", 128'(memreq_msg), 128'(xmsg));
    tick();
    dmemreq_val = 1'b0;
    #1;
    chk("lock_then_imem", 128'(outs()), 128'(6'b110000));
    chk("lock_then_imem_msg", 128'(memreq_msg), 128'(imsg));
    do_reset();

    // Randomized traffic against a queue-based reference model
    mq.delete();
    m_last = 1'b0; held_v = 1'b0; held_p = 1'b0; i_hold = 1'b0; d_hold = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!i_hold) begin imemreq_val = 1'($urandom_range(0, 1)); imemreq_msg = rnd_req(); end
      if (!d_hold) begin dmemreq_val = 1'($urandom_range(0, 1)); dmemreq_msg = rnd_req(); end
      memreq_rdy   = ($urandom_range(0, 3) != 0);
      imemresp_rdy = 1'($urandom_range(0, 1));
      dmemresp_rdy = 1'($urandom_range(0, 1));
      has          = (mq.size() > 0);
      memresp_val  = has && ($urandom_range(0, 2) != 0);
      memresp_msg  = has ? (RESP'(mq[0].msg) ^ RESP'(46'h2A5A)) : '0;

      // Which port wins: a held request, else the one not served last, else whoever asks
      cand_v = 1'b0; cand = 1'b0;
      if (held_v) begin cand_v = 1'b1; cand = held_p; end
      else if (imemreq_val && dmemreq_val) begin cand_v = 1'b1; cand = ~m_last; end
      else if (imemreq_val) begin cand_v = 1'b1; cand = 1'b0; end
      else if (dmemreq_val) begin cand_v = 1'b1; cand = 1'b1; end
      full    = (mq.size() == MAXO);
      e_mval  = cand_v && !full;
      e_fire  = e_mval && memreq_rdy;
      e_iv    = has && !mq[0].port && memresp_val;
      e_dv    = has && mq[0].port && memresp_val;
      e_mrr   = has && (mq[0].port ? dmemresp_rdy : imemresp_rdy);
      e_rfire = memresp_val && e_mrr;
      #1;
      chk($sformatf("rand_outs[%0d]", n), 128'(outs()),
          128'({e_mval, e_mval && memreq_rdy && !cand, e_mval && memreq_rdy && cand,
                e_iv, e_dv, e_mrr}));
      if (e_mval)
        chk($sformatf("rand_req_msg[%0d]", n), 128'(memreq_msg), 128'(cand ? dmemreq_msg : imemreq_msg));
      if (e_iv) chk($sformatf("rand_iresp[%0d]", n), 128'(imemresp_msg), 128'(memresp_msg));
      if (e_dv) chk($sformatf("rand_dresp[%0d]", n), 128'(dmemresp_msg), 128'(memresp_msg));

      if (e_rfire) void'(mq.pop_front());
      if (e_fire) begin
        mq.push_back('{port: cand, msg: (cand ? dmemreq_msg : imemreq_msg)});
        m_last = cand;
      end
      held_v = e_mval && !memreq_rdy;
      held_p = cand;
      i_hold = imemreq_val && !(e_fire && !cand);
      d_hold = dmemreq_val && !(e_fire && cand);
      @(posedge clk);
      #1;
    end
    do_reset();

    // Asynchronous reset with 3 outstanding requests
    imemreq_val = 1'b1; memreq_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      imemreq_msg = rnd_req();
      tick();
    end
    imemreq_val = 1'b1; dmemreq_val = 1'b1; dmemreq_msg = dmsg;
    memresp_val = 1'b1; imemresp_rdy = 1'b1; dmemresp_rdy = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("async_reset_outs", 128'(outs()), 128'(6'b000000));
    tick();
    chk("async_reset_hold", 128'(outs()), 128'(6'b000000));
    reset = 1'b1;
    #1;
    chk("post_reset_grant", 128'(outs()), 128'(6'b101000));
    chk("post_reset_msg", 128'(memreq_msg), 128'(dmsg));
    tick();
    memresp_val = 1'b0;
`ifdef PLAB2_PROC_MEM_ARB_CHECK_EN
    chk("proto_err_set", 128'(proto_err), 128'(1'b1));
    tick();
    chk("proto_err_sticky", 128'(proto_err), 128'(1'b1));
`else
    chk("proto_err_tied", 128'(proto_err), 128'(1'b0));
`endif
    do_reset();
    chk("proto_err_after_reset", 128'(proto_err), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
